sha3_msg_feeder: RTL

SHA3_MSG_FEEDER -- requirements
Module: sha3_msg_feeder

---
 rtl/sha3_msg_feeder.sv | 116 +++++++++++
 1 files changed

// File: rtl/sha3_msg_feeder.sv
// Packs an upstream byte stream into 64-bit words for a SHA-3 core and marks the final word.
// Optional SHA3_FEEDER_LEN_EN adds a saturating msg_len count of accepted bytes.
module sha3_msg_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        msg_end,
  output logic [63:0] in,
  output logic        in_ready,
  output logic        is_last,
  output logic [3:0]  byte_num,
  input  logic        buffer_full,
  output logic        done
`ifdef SHA3_FEEDER_LEN_EN
  ,
  output logic [31:0] msg_len
`endif
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    SEND      = 2'd1,
    SEND_LAST = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] word;
  logic        last_pend;
  logic [3:0]  bn;
  logic        pending;

  assign pending = (state == SEND) || (state == SEND_LAST);

  // NOTE: in_ready is combinational on buffer_full so a word is never offered
  // in a cycle the core cannot take it; everything else decodes from flops.
  assign s_ready  = (state == FILL);
  assign done     = (state == DONE);
  assign in_ready = pending && !buffer_full;
  assign in       = in_ready ? word : 64'd0;
  assign is_last  = in_ready && (state == SEND_LAST);
  assign byte_num = is_last ? bn : 4'd0;

  // NOTE: reset is synchronous; all state uses non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      cnt       <= 3'd0;
      word      <= 64'd0;
      last_pend <= 1'b0;
      bn        <= 4'd0;
    end else begin
      unique case (state)
        FILL: begin
          if (s_valid) begin
            // Lane 0 is bits [63:56]; ~cnt equals 7-cnt for a 3-bit count.
            word[{~cnt, 3'b000} +: 8] <= s_data;
            if (cnt == 3'd7) begin
              cnt       <= 3'd0;
              last_pend <= s_last;
              state     <= SEND;
            end else if (s_last) begin
              cnt   <= 3'd0;
              bn    <= {1'b0, cnt} + 4'd1;
              state <= SEND_LAST;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end else if (msg_end && (cnt == 3'd0)) begin
            bn    <= 4'd0;
            state <= SEND_LAST;
          end
        end
        SEND: begin
          if (!buffer_full) begin
            // Clearing here keeps unused lanes of a short final word at zero.
            word <= 64'd0;
            if (last_pend) begin
              last_pend <= 1'b0;
              bn        <= 4'd0;
              state     <= SEND_LAST;
            end else begin
              state <= FILL;
            end
          end
        end
        SEND_LAST: begin
          if (!buffer_full) begin
            word  <= 64'd0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end

`ifdef SHA3_FEEDER_LEN_EN
  // Bytes are only accepted in FILL, so the count freezes once DONE is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len <= 32'd0;
    end else if (s_valid && (state == FILL) && (msg_len != 32'hFFFF_FFFF)) begin
      msg_len <= msg_len + 32'd1;
    end
  end
`endif

endmodule
